// File: rtl/fetch_control_fsm_if.sv
// Interface that bundles the fetch sequencer's inputs and decoded control outputs.
// The master modport is the sequencer side. The slave modport is the PC/ROM/datapath side.
interface fetch_control_fsm_if #(
  parameter int PC_W    = 3,
  parameter int INSTR_W = 12
);
  logic               go;
  logic               step_mode;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic               pc_ld;
  logic [INSTR_W-1:0] ir;
  logic [2:0]         rf_ra1;
  logic [2:0]         rf_ra2;
  logic [2:0]         rf_wa;
  logic               rf_we;
  logic               wb_sel;
  logic               alu_sub;
  logic [3:0]         dm_addr;
  logic               dm_we;
  logic               busy;
  logic               halted;

  modport master (
    input  go, step_mode, pc, instr,
    output pc_ld, ir, rf_ra1, rf_ra2, rf_wa, rf_we, wb_sel, alu_sub,
           dm_addr, dm_we, busy, halted
  );

  modport slave (
    output go, step_mode, pc, instr,
    input  pc_ld, ir, rf_ra1, rf_ra2, rf_wa, rf_we, wb_sel, alu_sub,
           dm_addr, dm_we, busy, halted
  );
endinterface

// File: rtl/fetch_control_fsm.sv
// Three-cycle FETCH/DECODE/EXEC sequencer that sits after the program counter.
// It latches each ROM word, decodes it into register-file, ALU and memory controls, and pulses pc_ld.
module fetch_control_fsm #(
  parameter int PC_W    = 3,
  parameter int INSTR_W = 12,
  parameter bit WRAP_EN = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_control_fsm_if.master  bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALTED} state_e;

  localparam logic [2:0]      OP_STORE = 3'b000;
  localparam logic [2:0]      OP_LOAD  = 3'b001;
  localparam logic [2:0]      OP_ADD   = 3'b101;
  localparam logic [2:0]      OP_SUB   = 3'b110;
  localparam logic [2:0]      OP_HALT  = 3'b111;
  localparam logic [PC_W-1:0] PC_LAST  = '1;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [2:0]         op;

  logic       pc_ld, rf_we, wb_sel, alu_sub, dm_we, dec_v, exec_v;
  logic [2:0] rf_ra1, rf_ra2, rf_wa;
  logic [3:0] dm_addr;

  assign op = ir_q[11:9];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:   if (bus.go) state_d = S_FETCH;
      S_FETCH:  begin
        ir_d    = bus.instr;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op == OP_HALT)                     state_d = S_HALTED;
        else if (bus.pc == PC_LAST && !WRAP_EN) state_d = S_HALTED;
        else if (bus.step_mode) begin
          // Clear ir when the sequencer goes back to IDLE, so every output is 0 while idle.
          state_d = S_IDLE;
          ir_d    = '0;
        end
        else                                   state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Decoded fields are valid from DECODE through EXEC. The write strobes are driven only in EXEC.
  always_comb begin
    dec_v   = (state_q == S_DECODE) || (state_q == S_EXEC);
    exec_v  = (state_q == S_EXEC);
    rf_ra1  = '0;
    rf_ra2  = '0;
    rf_wa   = '0;
    rf_we   = 1'b0;
    wb_sel  = 1'b0;
    alu_sub = 1'b0;
    dm_addr = '0;
    dm_we   = 1'b0;
    if (dec_v) begin
      case (op)
        OP_STORE: begin
          dm_addr = ir_q[7:4];
          rf_ra2  = ir_q[2:0];
          dm_we   = exec_v;
        end
        OP_LOAD: begin
          dm_addr = ir_q[7:4];
          rf_wa   = ir_q[2:0];
          wb_sel  = 1'b1;
          rf_we   = exec_v;
        end
        OP_ADD, OP_SUB: begin
          rf_wa   = ir_q[8:6];
          rf_ra1  = ir_q[5:3];
          rf_ra2  = ir_q[2:0];
          alu_sub = (op == OP_SUB);
          rf_we   = exec_v;
        end
        default: ;
      endcase
    end
    pc_ld = exec_v && (op != OP_HALT);
  end

  assign bus.pc_ld   = pc_ld;
  assign bus.ir      = ir_q;
  assign bus.rf_ra1  = rf_ra1;
  assign bus.rf_ra2  = rf_ra2;
  assign bus.rf_wa   = rf_wa;
  assign bus.rf_we   = rf_we;
  assign bus.wb_sel  = wb_sel;
  assign bus.alu_sub = alu_sub;
  assign bus.dm_addr = dm_addr;
  assign bus.dm_we   = dm_we;
  assign bus.busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign bus.halted  = (state_q == S_HALTED);
endmodule

// File: tb/tb_fetch_control_fsm.sv
// Bench for fetch_control_fsm. It runs directed scenarios and then random go/step/reset/ROM traffic.
// A behavioural model of the sequencer is compared with the DUT outputs on every cycle.
module tb_fetch_control_fsm;
  localparam int MI = 0, MF = 1, MD = 2, ME = 3, MH = 4;
  localparam logic [11:0] NOP = 12'h400, HALT = 12'hE00;

  logic clk = 1'b0, reset = 1'b1, rst2 = 1'b1, chk_en = 1'b0;
  always #5 clk = ~clk;

  fetch_control_fsm_if #(.PC_W(3), .INSTR_W(12)) bus ();
  fetch_control_fsm_if #(.PC_W(3), .INSTR_W(12)) bus2 ();

  fetch_control_fsm #(.PC_W(3), .INSTR_W(12), .WRAP_EN(1'b0)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  fetch_control_fsm #(.PC_W(3), .INSTR_W(12), .WRAP_EN(1'b1)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2));

  logic [11:0] rom [8];
  assign bus.instr  = rom[bus.pc];
  assign bus2.instr = NOP;

  int n_chk = 0, n_pass = 0, pl_cnt = 0, cnt2 = 0;
  logic [2:0] pc_at9 = 3'd7;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    else n_pass++;
  endtask

  // Reference model. It tracks the sequencer phase, the latched word and the program counter it feeds.
  int         m_st = MI;
  logic [11:0] m_ir = '0;
  int         m_pc = 0;

  function automatic logic [31:0] expect_out(input int st, input logic [11:0] ir);
    logic [2:0] op = ir[11:9];
    logic [2:0] ra1 = 0, ra2 = 0, wa = 0;
    logic [3:0] dma = 0;
    logic rfwe = 0, wbs = 0, sub = 0, dmwe = 0, pcld;
    bit ex = (st == ME);
    if (st == MD || st == ME) begin
      if (op == 3'd0) begin dma = ir[7:4]; ra2 = ir[2:0]; dmwe = ex; end
      else if (op == 3'd1) begin dma = ir[7:4]; wa = ir[2:0]; wbs = 1; rfwe = ex; end
      else if (op == 3'd5 || op == 3'd6) begin
        wa = ir[8:6]; ra1 = ir[5:3]; ra2 = ir[2:0]; sub = (op == 3'd6); rfwe = ex;
      end
    end
    pcld = ex && op != 3'd7;
    return {pcld, ir, ra1, ra2, wa, rfwe, wbs, sub, dma, dmwe,
            logic'(st == MF || st == MD || st == ME), logic'(st == MH)};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_st = MI; m_ir = '0; m_pc = 0;
    end else begin
      case (m_st)
        MI: if (bus.go) m_st = MF;
        MF: begin m_ir = rom[m_pc]; m_st = MD; end
        MD: m_st = ME;
        ME: begin
          if (m_ir[11:9] == 3'd7) m_st = MH;
          else begin
            if (m_pc == 7) m_st = MH;
            else if (bus.step_mode) begin m_st = MI; m_ir = '0; end
            else m_st = MF;
            m_pc = (m_pc + 1) % 8;
          end
        end
        default: m_st = MH;
      endcase
    end
    bus.pc <= 3'(m_pc);
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle_outputs",
            {bus.pc_ld, bus.ir, bus.rf_ra1, bus.rf_ra2, bus.rf_wa, bus.rf_we, bus.wb_sel,
             bus.alu_sub, bus.dm_addr, bus.dm_we, bus.busy, bus.halted},
            expect_out(m_st, m_ir));
    if (bus.pc_ld) pl_cnt++;
    if (bus2.pc_ld) begin
      cnt2++;
      if (cnt2 == 9) pc_at9 = bus2.pc;
    end
  end

  // Program counter for the wrapping instance. It is advanced by that instance's own pc_ld pulse.
  always @(posedge clk) begin
    if (rst2) bus2.pc <= '0;
    else if (bus2.pc_ld) bus2.pc <= bus2.pc + 3'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.go = 1'b0;
    tick(); tick();
    reset = 1'b0; pl_cnt = 0; chk_en = 1'b1;
  endtask

  function automatic logic [11:0] rand_instr();
    logic [2:0] op = 3'($urandom_range(0, 7));
    if (op == 3'd7 && $urandom_range(0, 7) != 0) op = 3'd5;
    return {op, 9'($urandom)};
  endfunction

  initial begin
    bus.go = 1'b0; bus.step_mode = 1'b0;
    bus2.go = 1'b0; bus2.step_mode = 1'b0;
    foreach (rom[i]) rom[i] = NOP;
    rom[0] = 12'b101_001_010_011;
    do_reset();
    rst2 = 1'b0; bus2.go = 1'b1;

    // ADD R1,R2,R3 in free-run mode. The remaining addresses hold NOPs, so the run halts after address 7.
    bus.go = 1'b1; tick(); bus.go = 1'b0; bus2.go = 1'b0;
    check("fetch_c1_busy", 32'(bus.busy), 32'd1);
    check("fetch_c1_pcld", 32'(bus.pc_ld), 32'd0);
    tick(); tick();
    check("add_rf_wa",  32'(bus.rf_wa), 32'd1);
    check("add_rf_ra1", 32'(bus.rf_ra1), 32'd2);
    check("add_rf_ra2", 32'(bus.rf_ra2), 32'd3);
    check("add_ctl", 32'({bus.rf_we, bus.alu_sub, bus.pc_ld}), 32'b101);
    tick();
    check("c4_fetch", 32'({bus.busy, bus.pc_ld, bus.rf_we}), 32'b100);
    for (int k = 0; k < 100 && !bus.halted; k++) tick();
    check("nowrap_halted", 32'(bus.halted), 32'd1);
    check("nowrap_pcld_cnt", 32'(pl_cnt), 32'd8);
    bus.go = 1'b1; tick(); tick(); bus.go = 1'b0; tick();
    check("halted_ignores_go", 32'({bus.halted, bus.busy}), 32'b10);
    check("halted_pcld_cnt", 32'(pl_cnt), 32'd8);

    // LOAD R5,mem[9], then STORE mem[4],R5, then HALT at address 2.
    do_reset();
    rom[0] = 12'h295; rom[1] = 12'h045; rom[2] = HALT;
    bus.go = 1'b1; tick(); bus.go = 1'b0; tick(); tick();
    check("load_ctl", 32'({bus.rf_we, bus.wb_sel, bus.dm_we}), 32'b110);
    check("load_rf_wa", 32'(bus.rf_wa), 32'd5);
    check("load_dm_addr", 32'(bus.dm_addr), 32'd9);
    tick(); tick(); tick();
    check("store_ctl", 32'({bus.dm_we, bus.rf_we}), 32'b10);
    check("store_dm_addr", 32'(bus.dm_addr), 32'd4);
    check("store_rf_ra2", 32'(bus.rf_ra2), 32'd5);
    check("store_rf_wa", 32'(bus.rf_wa), 32'd0);
    tick(); tick(); tick();
    check("halt_exec_pcld", 32'(bus.pc_ld), 32'd0);
    tick();
    check("halt_state", 32'({bus.halted, bus.busy}), 32'b10);
    check("halt_pcld_cnt", 32'(pl_cnt), 32'd2);

    // Step mode. go is held through the whole instruction and must not start a second one.
    do_reset();
    foreach (rom[i]) rom[i] = NOP;
    bus.step_mode = 1'b1; bus.go = 1'b1;
    tick(); tick(); tick(); bus.go = 1'b0; tick();
    check("step_idle", 32'({bus.busy, bus.halted}), 32'b00);
    check("step_ir_clear", 32'(bus.ir), 32'd0);
    tick(); tick();
    check("step_one_pcld", 32'(pl_cnt), 32'd1);
    bus.go = 1'b1; tick(); bus.go = 1'b0; tick(); tick(); tick(); tick();
    check("step_two_pcld", 32'(pl_cnt), 32'd2);
    check("step_idle2", 32'(bus.busy), 32'd0);

    // Reset asserted while the sequencer is in DECODE.
    bus.step_mode = 1'b0;
    do_reset();
    rom[0] = 12'h295;
    bus.go = 1'b1; tick(); bus.go = 1'b0; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_dec_idle", 32'({bus.busy, bus.halted}), 32'b00);
    check("rst_dec_ir", 32'(bus.ir), 32'd0);
    tick(); tick(); tick(); tick();
    check("rst_dec_no_pulse", 32'(pl_cnt), 32'd0);

    // Random traffic. The per-cycle model comparison does the checking.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      bus.go = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) bus.step_mode = ~bus.step_mode;
      rom[$urandom_range(0, 7)] = rand_instr();
      tick();
    end

    check("wrap_count", 32'(cnt2 >= 9), 32'd1);
    check("wrap_pc_at_9th", 32'(pc_at9), 32'd0);
    check("wrap_not_halted", 32'(bus2.halted), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
